// File: rtl/chaos_pkg.sv
// Shared definitions for the chaos automaton configuration loader:
// register map, control/status bit positions and the FSM state type.
package chaos_pkg;

   localparam int WORD_W_DEF = 32;

   // Register byte offsets inside the 256-byte Wishbone window
   localparam logic [7:0] ADR_CTRL   = 8'h00;
   localparam logic [7:0] ADR_STATUS = 8'h04;
   localparam logic [7:0] ADR_STEPS  = 8'h08;
   localparam logic [7:0] ADR_DATA   = 8'h0C;
   localparam logic [7:0] ADR_WCOUNT = 8'h10;

   // CTRL bit indices
   localparam int CTRL_RUN    = 0;
   localparam int CTRL_STEP   = 1;
   localparam int CTRL_IRQ_EN = 2;

   // STATUS bit indices
   localparam int STAT_BUSY = 0;
   localparam int STAT_DONE = 1;
   localparam int STAT_ERR  = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_RUN   = 2'd2
   } state_t;

   // Replace only the bytes whose select bit is set
   function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  sel);
      logic [31:0] res;
      res = old_val;
      for (int b = 0; b < 4; b++)
         if (sel[b]) res[8*b +: 8] = new_val[8*b +: 8];
      return res;
   endfunction

endpackage

// File: rtl/chaos_cfg_shifter.sv
// Configuration-chain shift register: parallel load, LSB-first serial
// shift with capture of the chain tail, and a 5-bit shift counter that
// flags the final shift of a word.
module chaos_cfg_shifter
   import chaos_pkg::*;
#(
   parameter int WORD_W = WORD_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [WORD_W-1:0] load_word,
   input  logic              shift,
   input  logic              ser_in,
   output logic              ser_out,
   output logic [WORD_W-1:0] word,
   output logic              last
);

   logic [4:0] cnt;

   // Load a new word, or shift one bit per enabled cycle while counting
   // NOTE: registers use non-blocking assignment so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         word <= '0;
         cnt  <= '0;
      end else if (load) begin
         word <= load_word;
         cnt  <= '0;
      end else if (shift) begin
         word <= {ser_in, word[WORD_W-1:1]};
         cnt  <= cnt + 5'd1;
      end
   end

   assign ser_out = word[0];
   assign last    = (cnt == 5'(WORD_W - 1));

endmodule

// File: rtl/chaos_config_loader.sv
// Wishbone-mapped loader for a cellular-automaton configuration chain.
// Serialises DATA writes into the chain while capturing its tail, and
// gates automaton evolution for a programmed number of cycles.
module chaos_config_loader
   import chaos_pkg::*;
#(
   parameter logic [31:0] BASE_ADR = 32'h3000_0000,
   parameter int          WORD_W   = WORD_W_DEF
) (
   input  logic        wb_clk_i,
   input  logic        wb_rstn_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   output logic        cfg_shift_o,
   output logic        cfg_data_o,
   input  logic        cfg_data_i,
   output logic        run_o,
   output logic        irq_o
);

   state_t            state;
   logic              ctrl_run, ctrl_irq_en, st_done, st_err;
   logic [31:0]       steps, run_cnt;
   logic [15:0]       wcount;
   logic [WORD_W-1:0] sr_word;
   logic              sr_out, sr_last;

   logic        in_window, req, wr, busy;
   logic        wr_ctrl, wr_status, wr_steps, wr_data;
   logic [2:0]  ctrl_new;
   logic        stop_req, bad_wr, start_shift, start_run, start_step, zero_run;
   logic        run_done, shift_done, set_done, clr_done, clr_err;
   logic [31:0] rdata;

   // Bus decode; the ~ack term limits each request to a single ack pulse
   assign in_window = (wbs_adr_i[31:8] == BASE_ADR[31:8]);
   assign req       = wbs_cyc_i & wbs_stb_i & in_window & ~wbs_ack_o;
   assign wr        = req & wbs_we_i;
   assign wr_ctrl   = wr & (wbs_adr_i[7:0] == ADR_CTRL);
   assign wr_status = wr & (wbs_adr_i[7:0] == ADR_STATUS);
   assign wr_steps  = wr & (wbs_adr_i[7:0] == ADR_STEPS);
   assign wr_data   = wr & (wbs_adr_i[7:0] == ADR_DATA);
   assign busy      = (state != ST_IDLE);

   // With byte 0 disabled a CTRL write leaves run/irq_en as they are
   assign ctrl_new = wbs_sel_i[0] ? wbs_dat_i[2:0] : {ctrl_irq_en, 1'b0, ctrl_run};

   assign stop_req    = wr_ctrl & (state == ST_RUN) & ~ctrl_new[CTRL_RUN];
   assign bad_wr      = (wr_ctrl | wr_steps | wr_data) & busy & ~stop_req;
   assign start_shift = wr_data & ~busy;
   assign start_run   = wr_ctrl & ~busy & ctrl_new[CTRL_RUN] & (steps != '0);
   assign zero_run    = wr_ctrl & ~busy & ctrl_new[CTRL_RUN] & (steps == '0);
   assign start_step  = wr_ctrl & ~busy & ~ctrl_new[CTRL_RUN] & ctrl_new[CTRL_STEP];
   assign run_done    = (state == ST_RUN) & (run_cnt == 32'd1) & ~stop_req;
   assign shift_done  = (state == ST_SHIFT) & sr_last;
   assign set_done    = run_done | zero_run;
   assign clr_done    = wr_status & wbs_sel_i[0] & wbs_dat_i[STAT_DONE];
   assign clr_err     = wr_status & wbs_sel_i[0] & wbs_dat_i[STAT_ERR];

   assign cfg_shift_o = (state == ST_SHIFT);
   assign run_o       = (state == ST_RUN);
   assign cfg_data_o  = cfg_shift_o & sr_out;

   chaos_cfg_shifter #(.WORD_W(WORD_W)) u_shifter (
      .clk       (wb_clk_i),
      .rst_n     (wb_rstn_i),
      .load      (start_shift),
      .load_word (WORD_W'(wbs_dat_i)),
      .shift     (cfg_shift_o),
      .ser_in    (cfg_data_i),
      .ser_out   (sr_out),
      .word      (sr_word),
      .last      (sr_last)
   );

   // Sequencer: IDLE -> SHIFT for one word, IDLE -> RUN for a step budget
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rstn_i) begin
         state   <= ST_IDLE;
         run_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start_shift) begin
                  state <= ST_SHIFT;
               end else if (start_run) begin
                  state   <= ST_RUN;
                  run_cnt <= steps;
               end else if (start_step) begin
                  state   <= ST_RUN;
                  run_cnt <= 32'd1;
               end
            end
            ST_SHIFT: if (sr_last) state <= ST_IDLE;
            ST_RUN: begin
               if (stop_req || run_cnt == 32'd1) state <= ST_IDLE;
               else run_cnt <= run_cnt - 32'd1;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Register file; a hardware set of done/err wins over a same-cycle clear
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rstn_i) begin
         ctrl_run    <= 1'b0;
         ctrl_irq_en <= 1'b0;
         steps       <= '0;
         st_done     <= 1'b0;
         st_err      <= 1'b0;
         wcount      <= '0;
      end else begin
         if (wr_ctrl && (!busy || stop_req)) ctrl_irq_en <= ctrl_new[CTRL_IRQ_EN];
         if (start_run) ctrl_run <= 1'b1;
         else if (run_done || stop_req) ctrl_run <= 1'b0;
         if (wr_steps && !busy) steps <= byte_merge(steps, wbs_dat_i, wbs_sel_i);
         st_done <= (st_done & ~clr_done) | set_done;
         st_err  <= (st_err & ~clr_err) | bad_wr;
         if (shift_done) wcount <= wcount + 16'd1;
      end
   end

   // Read mux; unimplemented offsets read as zero
   // NOTE: rdata gets a default before the case so no path infers a latch.
   always_comb begin
      rdata = '0;
      case (wbs_adr_i[7:0])
         ADR_CTRL: begin
            rdata[CTRL_RUN]    = ctrl_run;
            rdata[CTRL_IRQ_EN] = ctrl_irq_en;
         end
         ADR_STATUS: begin
            rdata[STAT_BUSY] = busy;
            rdata[STAT_DONE] = st_done;
            rdata[STAT_ERR]  = st_err;
         end
         ADR_STEPS:  rdata = steps;
         ADR_DATA:   rdata = 32'(sr_word);
         ADR_WCOUNT: rdata = {16'h0000, wcount};
         default:    rdata = '0;
      endcase
   end

   // Single-cycle acknowledge with registered read data
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rstn_i) begin
         wbs_ack_o <= 1'b0;
         wbs_dat_o <= '0;
      end else begin
         wbs_ack_o <= req;
         wbs_dat_o <= (req && !wbs_we_i) ? rdata : '0;
      end
   end

   // Level interrupt, registered from done qualified by irq_en
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rstn_i) irq_o <= 1'b0;
      else            irq_o <= st_done & ctrl_irq_en;
   end

endmodule
